// File: rtl/mapper_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_frame_ctrl_if
//  Description : Chunk-input and mapper-control bundle between the frame
//                sequencer (slave) and the buffer / mapper / IFFT side (master).
//  Revision    : 1.0
// ============================================================================
interface mapper_frame_ctrl_if;
    logic        in_valid;
    logic [35:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic        map_rst_n;
    logic [1:0]  mod;
    logic [17:0] x0;
    logic [17:0] x1;
    logic        run;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, map_rst_n, mod, x0, x1, run
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, map_rst_n, mod, x0, x1, run
    );
endinterface
`default_nettype wire

// File: rtl/mapper_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_frame_ctrl
//  Description : Frame sequencer for the 6-subcarrier mapper; issues 8 runs
//                per OFDM symbol, SIGNAL in BPSK, pads aborted symbols.
//  Revision    : 1.0
// ============================================================================
module mapper_frame_ctrl #(
    parameter int SYM_W       = 12,
    parameter int MAP_RST_CYC = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             frame_start,
    input  wire logic [1:0]       rate_mod,
    input  wire logic [SYM_W-1:0] n_sym,
    input  wire logic             abort,
    mapper_frame_ctrl_if.slave    bus,
    output logic      [SYM_W-1:0] sym_cnt,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  aborted
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MRST = 3'd1;
    localparam logic [2:0] S_SIG  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] MCNT_LAST = 2'(MAP_RST_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [1:0]       r_rate;
    logic [SYM_W-1:0] r_nsym;
    logic [SYM_W-1:0] r_sym_cnt;
    logic             r_aborted;
    logic [2:0]       r_rc;
    logic [1:0]       r_mcnt;
    logic [1:0]       r_mod;
    logic             r_pad_sig;

    logic             w_run;
    logic             w_in_ready;
    logic [17:0]      w_x0;
    logic [17:0]      w_x1;
    logic             w_map_rst_n;
    logic             w_sym_end;
    logic             w_abort_exit;
    logic [2:0]       w_abort_to;
    logic [SYM_W-1:0] w_cnt_next;

    assign w_sym_end  = w_run && (r_rc == 3'd7);
    assign w_cnt_next = r_sym_cnt + SYM_W'(1);
    // Mid-symbol abort must finish the symbol with padding; only an untouched one can end at once.
    assign w_abort_to = ((r_rc == 3'd0) && !w_run) ? S_DONE : S_PAD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_abort_exit = 1'b0;
        case (r_state)
            S_IDLE: if (frame_start) w_next_state = S_MRST;
            S_MRST: begin
                if (abort) begin
                    w_next_state = S_DONE;
                    w_abort_exit = 1'b1;
                end else if (r_mcnt == MCNT_LAST) begin
                    w_next_state = S_SIG;
                end
            end
            S_SIG: begin
                if (w_sym_end) begin
                    w_abort_exit = abort;
                    w_next_state = (abort || (r_nsym == '0)) ? S_DONE : S_DATA;
                end else if (abort) begin
                    w_next_state = w_abort_to;
                    w_abort_exit = (w_abort_to == S_DONE);
                end
            end
            S_DATA: begin
                if (w_sym_end) begin
                    w_abort_exit = abort;
                    if (abort || (w_cnt_next == r_nsym)) w_next_state = S_DONE;
                end else if (abort) begin
                    w_next_state = w_abort_to;
                    w_abort_exit = (w_abort_to == S_DONE);
                end
            end
            S_PAD: begin
                if (w_sym_end) begin
                    w_next_state = S_DONE;
                    w_abort_exit = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_run       = 1'b0;
        w_in_ready  = 1'b0;
        w_x0        = '0;
        w_x1        = '0;
        w_map_rst_n = 1'b1;
        case (r_state)
            S_MRST: w_map_rst_n = 1'b0;
            S_SIG, S_DATA: begin
                w_in_ready = bus.out_ready;
                w_run      = bus.in_valid & bus.out_ready;
                w_x0       = bus.in_data[17:0];
                w_x1       = bus.in_data[35:18];
            end
            S_PAD:   w_run = bus.out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rate    <= '0;
            r_nsym    <= '0;
            r_sym_cnt <= '0;
            r_aborted <= 1'b0;
            r_rc      <= '0;
            r_mcnt    <= '0;
            r_mod     <= '0;
            r_pad_sig <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && frame_start) begin
                r_rate    <= rate_mod;
                r_nsym    <= n_sym;
                r_sym_cnt <= '0;
                r_aborted <= 1'b0;
                r_rc      <= '0;
                r_mcnt    <= '0;
                r_mod     <= '0;
            end
            if (r_state == S_MRST) r_mcnt <= r_mcnt + 2'd1;
            if (w_run) r_rc <= r_rc + 3'd1;
            if ((r_state == S_SIG) && (w_next_state == S_DATA)) r_mod <= r_rate;
            // A padded SIGNAL symbol is not a data symbol and must not count.
            if (w_sym_end && ((r_state == S_DATA) || ((r_state == S_PAD) && !r_pad_sig)))
                r_sym_cnt <= w_cnt_next;
            if ((r_state != S_PAD) && (w_next_state == S_PAD)) r_pad_sig <= (r_state == S_SIG);
            if (w_abort_exit) r_aborted <= 1'b1;
        end
    end

    assign bus.run       = w_run;
    assign bus.in_ready  = w_in_ready;
    assign bus.x0        = w_x0;
    assign bus.x1        = w_x1;
    assign bus.map_rst_n = w_map_rst_n;
    assign bus.mod       = r_mod;
    assign sym_cnt       = r_sym_cnt;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_DONE);
    assign aborted       = r_aborted;

endmodule
`default_nettype wire
